// File: rtl/dir_ctrl.sv
// Snake direction controller: per-button synchronize + debounce, priority turn request, committed direction.
// Define DIR_QUEUE_EN to buffer turns in a 2-entry queue drained on frame_tick; otherwise turns apply immediately.
module dir_db #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic clean
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= '0;
      cnt   <= '0;
      clean <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      if (sync[1] == clean) cnt <= '0;
      else if (cnt == LAST) begin
        clean <= ~clean;
        cnt   <= '0;
      end else if (cnt != '1) cnt <= cnt + 1'b1;
    end
  end
endmodule

module dir_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] buttons,
  input  logic       frame_tick,
  input  logic       game_rst,
  output logic [1:0] dir,
  output logic [3:0] clean,
  output logic       press_evt
);
  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic       vld;
    logic [1:0] d;
  } turn_req_t;

  logic [NUM_LANES-1:0] clean_d, rise;
  turn_req_t            req;
  logic [1:0]           dir_n;

  dir_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_LANES-1:0] (
    .clk  (clk),
    .rst  (rst),
    .btn  (buttons),
    .clean(clean)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) clean_d <= '0;
    else      clean_d <= clean;
  end

  assign rise      = clean & ~clean_d;
  assign press_evt = |rise;

  // Button bits map to direction codes: left=0, right=1, up=2, down=3; left wins.
  always_comb begin
    req.vld = |rise;
    if (rise[1])      req.d = 2'd0;
    else if (rise[0]) req.d = 2'd1;
    else if (rise[2]) req.d = 2'd2;
    else              req.d = 2'd3;
  end

`ifdef DIR_QUEUE_EN
  logic [1:0][1:0] q, q_n;
  logic [1:0]      qcnt, qcnt_n;
  logic [1:0]      ref_dir;

  // Pop first, then check the request against the post-pop tail (or new dir).
  always_comb begin
    dir_n   = dir;
    q_n     = q;
    qcnt_n  = qcnt;
    ref_dir = dir;
    if (frame_tick && qcnt != 2'd0) begin
      dir_n  = q[0];
      q_n[0] = q[1];
      qcnt_n = qcnt - 2'd1;
    end
    if (qcnt_n == 2'd2)      ref_dir = q_n[1];
    else if (qcnt_n == 2'd1) ref_dir = q_n[0];
    else                     ref_dir = dir_n;
    // Same axis means equal or opposite: both are dropped.
    if (req.vld && req.d[1] != ref_dir[1] && qcnt_n != 2'd2) begin
      q_n[qcnt_n[0]] = req.d;
      qcnt_n         = qcnt_n + 2'd1;
    end
    if (game_rst) begin
      dir_n  = 2'd0;
      qcnt_n = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir  <= 2'd0;
      q    <= '0;
      qcnt <= 2'd0;
    end else begin
      dir  <= dir_n;
      q    <= q_n;
      qcnt <= qcnt_n;
    end
  end
`else
  logic unused_tick;
  assign unused_tick = frame_tick;

  always_comb begin
    dir_n = dir;
    if (req.vld && req.d[1] != dir[1]) dir_n = req.d;
    if (game_rst) dir_n = 2'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dir <= 2'd0;
    else      dir <= dir_n;
  end
`endif
endmodule

// File: tb/tb_dir_ctrl.sv
// Randomized scoreboard bench for dir_ctrl: abstract turn model feeds expected press/dir events to a monitor.
module tb_dir_ctrl;
  localparam int DB = 4;
`ifdef DIR_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b1;
  logic [3:0] buttons = 4'b0;
  logic       frame_tick = 1'b0, game_rst = 1'b0;
  logic [1:0] dir;
  logic [3:0] clean;
  logic       press_evt;

  int checks = 0, failures = 0, cyc_n = 0;
  int exp_dir_q[$];
  int exp_pcyc_q[$];
  int exp_pclean_q[$];
  int mdir = 0;
  int mq[$];
  logic [1:0] last_dir = 2'd0;

  dir_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .buttons(buttons), .frame_tick(frame_tick),
    .game_rst(game_rst), .dir(dir), .clean(clean), .press_evt(press_evt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int opp(int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 3 : 2;
  endfunction

  function automatic int prio(logic [3:0] m);
    if (m[1]) return 0;
    if (m[0]) return 1;
    if (m[2]) return 2;
    return 3;
  endfunction

  // Abstract turn rules: restart, then pop, then accept against the reference direction.
  task automatic model_step(bit tick, bit grst, bit rv, int rq);
    int nd, refd;
    nd = mdir;
    if (grst) begin
      nd = 0;
      mq.delete();
    end else begin
      if (QEN && tick && mq.size() > 0) nd = mq.pop_front();
      refd = (QEN && mq.size() > 0) ? mq[$] : nd;
      if (rv && rq != refd && rq != opp(refd) && (!QEN || mq.size() < 2)) begin
        if (QEN) mq.push_back(rq);
        else     nd = rq;
      end
    end
    if (nd != mdir) exp_dir_q.push_back(nd);
    mdir = nd;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(bit t, bit g);
    frame_tick = t;
    game_rst   = g;
    model_step(t, g, 1'b0, 0);
    cyc();
    frame_tick = 1'b0;
    game_rst   = 1'b0;
  endtask

  // coin: 0 none, 1 frame_tick, 2 game_rst in the request cycle
  task automatic press(logic [3:0] m, bit lng, int coin);
    int hold;
    buttons = m;
    if (!lng) begin
      hold = $urandom_range(1, 3);
      repeat (hold) cyc();
      buttons = 4'b0;
      repeat (8) cyc();
      return;
    end
    hold = $urandom_range(8, 12);
    repeat (6) cyc();
    frame_tick = (coin == 1);
    game_rst   = (coin == 2);
    exp_pcyc_q.push_back(cyc_n);
    exp_pclean_q.push_back(int'(m));
    model_step(coin == 1, coin == 2, 1'b1, prio(m));
    cyc();
    frame_tick = 1'b0;
    game_rst   = 1'b0;
    if (coin == 2) chk("grst_keeps_clean", clean, m);
    repeat (hold - 7) cyc();
    buttons = 4'b0;
    repeat (10) cyc();
  endtask

  always @(negedge clk) begin
    if (press_evt) begin
      if (exp_pcyc_q.size() == 0) chk("spurious_press", 1, 0);
      else begin
        chk("press_cycle", cyc_n, exp_pcyc_q.pop_front());
        chk("press_clean", clean, exp_pclean_q.pop_front());
      end
    end
    if (dir != last_dir) begin
      if (exp_dir_q.size() == 0) chk("spurious_dir", dir, last_dir);
      else chk("dir_change", dir, exp_dir_q.pop_front());
      last_dir = dir;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    #1 rst = 1'b0;
    #2;
    chk("rst_dir", dir, 0);
    chk("rst_clean", clean, 0);
    chk("rst_press", press_evt, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cyc();

    // short glitches and falling edges never produce a press
    press(4'b0010, 1'b0, 0);
    press(4'b0100, 1'b1, 0);
    tick(1'b1, 1'b0);
    // right reversed, up queued, down reversed
    tick(1'b0, 1'b1);
    press(4'b0001, 1'b1, 0);
    press(4'b0100, 1'b1, 0);
    press(4'b1000, 1'b1, 0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    // fill queue, overflow dropped
    tick(1'b0, 1'b1);
    press(4'b0100, 1'b1, 0);
    press(4'b0001, 1'b1, 0);
    press(4'b1000, 1'b1, 0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    // pop and request in the same cycle
    tick(1'b0, 1'b1);
    press(4'b0100, 1'b1, 0);
    press(4'b0001, 1'b1, 1);
    tick(1'b1, 1'b0);
    // restart wins over tick and same-cycle request
    press(4'b1000, 1'b1, 0);
    press(4'b0010, 1'b1, 0);
    tick(1'b1, 1'b1);
    press(4'b0100, 1'b1, 2);
    tick(1'b1, 1'b0);
    // simultaneous presses resolved by priority
    press(4'b1111, 1'b1, 0);
    press(4'b1101, 1'b1, 0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);

    for (int n = 0; n < 50; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2)       tick(1'b1, 1'b0);
      else if (r == 2) tick(1'b0, 1'b1);
      else if (r == 3) tick(1'b1, 1'b1);
      else begin
        int c;
        c = $urandom_range(0, 5);
        press(4'($urandom_range(1, 15)), $urandom_range(0, 3) != 0, (c < 2) ? c + 1 : 0);
      end
    end

    // async reset in the middle of a debounce, with a clean bit high
    press(4'b0001, 1'b1, 0);
    press(4'b0100, 1'b1, 0);
    tick(1'b1, 1'b0);
    buttons = 4'b1000;
    repeat (6) cyc();
    exp_pcyc_q.push_back(cyc_n);
    exp_pclean_q.push_back(8);
    model_step(1'b0, 1'b0, 1'b1, 3);
    repeat (3) cyc();
    #2 rst = 1'b0;
    if (mdir != 0) exp_dir_q.push_back(0);
    mdir = 0;
    mq.delete();
    #1;
    chk("midrst_dir", dir, 0);
    chk("midrst_clean", clean, 0);
    chk("midrst_press", press_evt, 0);
    buttons = 4'b0;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    press(4'b0100, 1'b1, 0);
    tick(1'b1, 1'b0);
    repeat (4) cyc();

    chk("dir_q_drained", exp_dir_q.size(), 0);
    chk("press_q_drained", exp_pcyc_q.size(), 0);
    chk("final_dir", dir, mdir);
    chk("final_clean", clean, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
